// File: rtl/loop_scan_ctrl.sv
// Bracket-jump sequencer: scans instruction memory for the matching '[' / ']'
// and loads its address+1 into the fetch unit. Optional jump cache: LOOP_SCAN_CACHE_EN.
module loop_scan_ctrl #(
   parameter int unsigned     PC_W     = 16,
   parameter int unsigned     OP_W     = 8,
   parameter int unsigned     DEPTH_W  = 8,
   parameter logic [OP_W-1:0] OP_OPEN  = 8'h5B,
   parameter logic [OP_W-1:0] OP_CLOSE = 8'h5D
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_fwd,
   input  logic            start_bwd,
   input  logic [PC_W-1:0] pc,
   input  logic [OP_W-1:0] instruction,
   output logic [PC_W-1:0] scan_addr,
   output logic            busy,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_target,
   output logic            error
);

   typedef enum logic [2:0] {IDLE, FWD, BWD, DONE, FAULT} state_t;

   state_t               state;
   logic [DEPTH_W-1:0]   depth;
   logic                 is_open, is_close, grow, shrink, match, overflow, at_edge;
   logic [PC_W-1:0]      next_addr;

   assign is_open   = (instruction == OP_OPEN);
   assign is_close  = (instruction == OP_CLOSE);
   // In a backward scan the roles of the two brackets swap.
   assign grow      = (state == FWD) ? is_open  : is_close;
   assign shrink    = (state == FWD) ? is_close : is_open;
   assign match     = shrink && (depth == DEPTH_W'(1));
   assign overflow  = grow && (depth == '1);
   assign at_edge   = (state == FWD) ? (scan_addr == '1) : (scan_addr == '0);
   assign next_addr = (state == FWD) ? scan_addr + 1'b1 : scan_addr - 1'b1;

`ifdef LOOP_SCAN_CACHE_EN
   logic            c_valid, c_dir, cur_dir;
   logic [PC_W-1:0] c_src, c_target, cur_src;
   logic            hit;

   assign hit = c_valid && (c_dir == start_fwd) && (c_src == pc);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         depth     <= '0;
         scan_addr <= '0;
         busy      <= 1'b0;
         pc_load   <= 1'b0;
         pc_target <= '0;
         error     <= 1'b0;
`ifdef LOOP_SCAN_CACHE_EN
         c_valid   <= 1'b0;
         c_dir     <= 1'b0;
         c_src     <= '0;
         c_target  <= '0;
         cur_dir   <= 1'b0;
         cur_src   <= '0;
`endif
      end else begin
         pc_load <= 1'b0;
         case (state)
            IDLE: begin
               if (start_fwd || start_bwd) begin
                  error <= 1'b0;
                  busy  <= 1'b1;
`ifdef LOOP_SCAN_CACHE_EN
                  cur_dir <= start_fwd;
                  cur_src <= pc;
                  if (hit) begin
                     state     <= DONE;
                     pc_target <= c_target;
                     pc_load   <= 1'b1;
                  end else
`endif
                  begin
                     state     <= start_fwd ? FWD : BWD;
                     scan_addr <= start_fwd ? pc + 1'b1 : pc - 1'b1;
                     depth     <= DEPTH_W'(1);
                  end
               end
            end
            FWD, BWD: begin
               // Match takes priority: a match at the last address is not a wrap.
               if (match) begin
                  pc_target <= scan_addr + 1'b1;
                  pc_load   <= 1'b1;
                  state     <= DONE;
               end else if (overflow || at_edge) begin
                  error <= 1'b1;
                  state <= FAULT;
               end else begin
                  scan_addr <= next_addr;
                  if (grow)
                     depth <= depth + 1'b1;
                  else if (shrink)
                     depth <= depth - 1'b1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
`ifdef LOOP_SCAN_CACHE_EN
               c_valid  <= 1'b1;
               c_dir    <= cur_dir;
               c_src    <= cur_src;
               c_target <= pc_target;
`endif
            end
            FAULT: begin
               busy  <= 1'b1;
               error <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_loop_scan_ctrl.sv
// Self-checking bench for loop_scan_ctrl: scenario table, hand-written corner
// sequences and randomized scans checked against a memory-walk reference model.
module tb_loop_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_fwd = 1'b0, start_bwd = 1'b0;
   logic [15:0] pc = '0;
   logic [7:0]  instruction;
   logic [15:0] scan_addr, pc_target;
   logic        busy, pc_load, error;

   logic        s2_fwd = 1'b0;
   logic [15:0] pc2 = '0;
   logic [7:0]  instruction2;
   logic [15:0] scan_addr2, pc_target2;
   logic        busy2, pc_load2, error2;

   logic [7:0]  mem [0:65535];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign instruction  = mem[scan_addr];
   assign instruction2 = mem[scan_addr2];

   loop_scan_ctrl u_dut (
      .clk(clk), .reset(reset), .start_fwd(start_fwd), .start_bwd(start_bwd),
      .pc(pc), .instruction(instruction), .scan_addr(scan_addr), .busy(busy),
      .pc_load(pc_load), .pc_target(pc_target), .error(error)
   );

   loop_scan_ctrl #(.DEPTH_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .start_fwd(s2_fwd), .start_bwd(1'b0),
      .pc(pc2), .instruction(instruction2), .scan_addr(scan_addr2), .busy(busy2),
      .pc_load(pc_load2), .pc_target(pc_target2), .error(error2)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load_prog(input int base, input string prog);
      for (int i = 0; i < prog.len(); i++) mem[(base + i) & 16'hFFFF] = prog[i];
   endtask

   task automatic clear_prog(input int base, input int len);
      for (int i = 0; i < len; i++) mem[(base + i) & 16'hFFFF] = 8'h2B;
   endtask

   // Reference: walk memory from the start bracket, tracking nesting depth.
   // cyc is the cycle of pc_load (match) or of the first FAULT cycle.
   task automatic model(input int p, input bit fwd, input int dmax,
                        output bit flt, output int cyc, output logic [15:0] tgt);
      int a, depth;
      bit up, dn;
      a = p; depth = 1; flt = 0; cyc = -1; tgt = '0;
      for (int n = 1; n < 70000; n++) begin
         a = fwd ? a + 1 : a - 1;
         if (a < 0 || a > 65535) begin flt = 1; cyc = n; return; end
         up = fwd ? (mem[a] == 8'h5B) : (mem[a] == 8'h5D);
         dn = fwd ? (mem[a] == 8'h5D) : (mem[a] == 8'h5B);
         if (dn && depth == 1) begin tgt = 16'(a + 1); cyc = n + 1; return; end
         if (up) begin
            depth++;
            if (depth > dmax) begin flt = 1; cyc = n + 1; return; end
         end
         if (dn) depth--;
      end
   endtask

   // Pulse a start in cycle 0, then watch until pc_load or error (bounded).
   task automatic scan(input logic [15:0] p, input bit f, input bit b, input int budget,
                       output bit flt, output int cyc, output logic [15:0] tgt, output bit busy_ok);
      flt = 0; cyc = -1; tgt = '0; busy_ok = 1;
      @(negedge clk);
      pc = p; start_fwd = f; start_bwd = b;
      @(negedge clk);
      start_fwd = 0; start_bwd = 0;
      for (int c = 1; c <= budget; c++) begin
         if (!busy) busy_ok = 0;
         if (pc_load) begin cyc = c; tgt = pc_target; break; end
         if (error) begin flt = 1; cyc = c; break; end
         @(negedge clk);
      end
   endtask

   typedef struct {
      string       name;
      string       prog;
      int          base;
      logic [15:0] p;
      bit          f;
      bit          b;
      bit          flt;
      int          cyc;
      logic [15:0] tgt;
   } vec_t;

   vec_t tbl [6];

   initial begin
      bit          flt, bok, ok, mflt;
      int          cyc, mcyc, base;
      logic [15:0] tgt, mtgt;

      for (int i = 0; i < 65536; i++) mem[i] = 8'h2B;

      tbl[0] = '{"pair_fwd",   "[]",      10, 16'd10,     1, 0, 0, 2, 16'd12};
      tbl[1] = '{"nest_fwd",   "[+[-]>]",  0, 16'd0,      1, 0, 0, 7, 16'd7};
      tbl[2] = '{"nest_bwd",   "[+[-]>]",  0, 16'd6,      0, 1, 0, 7, 16'd1};
      tbl[3] = '{"both_start", "[]",      10, 16'd10,     1, 1, 0, 2, 16'd12};
      tbl[4] = '{"wrap_fwd",   "",         0, 16'hFFFD,   1, 0, 1, 3, 16'd0};
      tbl[5] = '{"wrap_bwd",   "",         0, 16'd3,      0, 1, 1, 4, 16'd0};

      reset = 1'b1;
      #12;
      check("rst_busy", busy, 0);
      check("rst_pc_load", pc_load, 0);
      check("rst_error", error, 0);
      check("rst_scan_addr", scan_addr, 0);
      check("rst_pc_target", pc_target, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         do_reset();
         load_prog(tbl[i].base, tbl[i].prog);
         scan(tbl[i].p, tbl[i].f, tbl[i].b, 50, flt, cyc, tgt, bok);
         check({tbl[i].name, "_fault"}, flt, tbl[i].flt);
         check({tbl[i].name, "_cycle"}, cyc, tbl[i].cyc);
         check({tbl[i].name, "_busy"}, bok, 1);
         if (tbl[i].flt) begin
            ok = 1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               if (!busy || !error || pc_load) ok = 0;
            end
            check({tbl[i].name, "_held"}, ok, 1);
            do_reset();
            check({tbl[i].name, "_clr_busy"}, busy, 0);
            check({tbl[i].name, "_clr_error"}, error, 0);
         end else begin
            check({tbl[i].name, "_target"}, tgt, tbl[i].tgt);
            @(negedge clk);
            check({tbl[i].name, "_idle"}, {busy, pc_load}, 0);
         end
         clear_prog(tbl[i].base, tbl[i].prog.len());
      end

      // Starts while busy are ignored.
      do_reset();
      load_prog(200, "[+++]");
      @(negedge clk);
      pc = 16'd200; start_fwd = 1;
      @(negedge clk);
      start_fwd = 0;
      @(negedge clk);
      pc = 16'd10; start_bwd = 1;
      @(negedge clk);
      start_bwd = 0;
      cyc = -1;
      for (int c = 3; c <= 20; c++) begin
         if (pc_load) begin cyc = c; tgt = pc_target; break; end
         @(negedge clk);
      end
      check("ignore_start_cycle", cyc, 5);
      check("ignore_start_target", tgt, 16'd205);
      clear_prog(200, 5);

      // Reset in the middle of a 10-instruction scan.
      do_reset();
      load_prog(100, "[++++++++]");
      @(negedge clk);
      pc = 16'd100; start_fwd = 1;
      @(negedge clk);
      start_fwd = 0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_busy_before", busy, 1);
      reset = 1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_scan_addr", scan_addr, 0);
      @(negedge clk);
      reset = 0;
      ok = 1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (pc_load || busy) ok = 0;
      end
      check("midrst_no_load", ok, 1);
      clear_prog(100, 10);

      // Depth overflow with a 2-bit counter: fourth '[' in a row.
      do_reset();
      load_prog(300, "[[[[");
      @(negedge clk);
      pc2 = 16'd300; s2_fwd = 1;
      @(negedge clk);
      s2_fwd = 0;
      cyc = -1; ok = 1;
      for (int c = 1; c <= 10; c++) begin
         if (pc_load2 || !busy2) ok = 0;
         if (error2) begin cyc = c; break; end
         @(negedge clk);
      end
      check("ovf_cycle", cyc, 4);
      check("ovf_busy_noload", ok, 1);
      do_reset();
      check("ovf_clr_error", error2, 0);
      clear_prog(300, 4);

`ifdef LOOP_SCAN_CACHE_EN
      do_reset();
      load_prog(10, "[]");
      scan(16'd10, 1, 0, 20, flt, cyc, tgt, bok);
      check("cache_first_cycle", cyc, 2);
      @(negedge clk);
      scan(16'd10, 1, 0, 20, flt, cyc, tgt, bok);
      check("cache_hit_cycle", cyc, 1);
      check("cache_hit_target", tgt, 16'd12);
      clear_prog(10, 2);
`endif

      // Randomized windows fenced so every scan terminates.
      do_reset();
      for (int t = 0; t < 30; t++) begin
         bit fwd;
         fwd  = 1'($urandom_range(0, 1));
         base = int'($urandom_range(1000, 50000));
         for (int i = base - 64; i <= base; i++) mem[i] = 8'h5B;
         for (int i = base + 41; i <= base + 104; i++) mem[i] = 8'h5D;
         for (int i = base + 1; i <= base + 40; i++) begin
            case ($urandom_range(0, 3))
               0: mem[i] = 8'h5B;
               1: mem[i] = 8'h5D;
               2: mem[i] = 8'h3E;
               default: mem[i] = 8'h2B;
            endcase
         end
         model(fwd ? base : base + 41, fwd, 255, mflt, mcyc, mtgt);
         scan(16'(fwd ? base : base + 41), fwd, !fwd, 200, flt, cyc, tgt, bok);
         check("rand_fault", flt, mflt);
         check("rand_cycle", cyc, mcyc);
         check("rand_target", tgt, mtgt);
         check("rand_busy", bok, 1);
         @(negedge clk);
         for (int i = base - 64; i <= base + 104; i++) mem[i] = 8'h2B;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/loop_scan_ctrl.md
Name: loop_scan_ctrl

Overview:
- Multi-cycle sequencer for bracket jumps in the BeeF core.
- Triggered when core_control resolves a taken loop branch: '[' with acc_zero=1, or ']' with acc_zero=0.
- Drives the instruction-fetch address, counting nesting depth, until it finds the matching bracket.
- Then loads that bracket's address+1 into the fetch unit via the pc_loaded / pc_write path; stalls the core while busy.

Parameters:
- PC_W, 16, program counter / instruction address width.
- OP_W, 8, instruction width.
- DEPTH_W, 8, nesting-depth counter width.
- OP_OPEN, 8'h5B, encoding of '['.
- OP_CLOSE, 8'h5D, encoding of ']'.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_fwd  input  1  pulse: taken '[' at pc; scan forward.
- start_bwd  input  1  pulse: taken ']' at pc; scan backward.
- pc  input  PC_W  address of the triggering bracket, sampled on start.
- instruction  input  OP_W  instruction at scan_addr, same cycle (combinational fetch).
- scan_addr  output  PC_W  fetch address during scan.
- busy  output  1  scan in progress; core must stall (no pc/acc/mem writes).
- pc_load  output  1  one-cycle pulse: fetch unit loads pc_target.
- pc_target  output  PC_W  matched bracket address + 1.
- error  output  1  sticky fault: depth overflow or address wrap without match.

Behaviour:
- Reset (async): state=IDLE; busy=0, pc_load=0, error=0, scan_addr=0, pc_target=0, depth=0.
- States: IDLE, FWD, BWD, DONE, FAULT.
- IDLE:
  - start_fwd → FWD, scan_addr=pc+1, depth=1.
  - start_bwd → BWD, scan_addr=pc-1, depth=1.
  - Both starts asserted together: fwd wins.
  - error is cleared on any accepted start.
- FWD, each cycle, examines instruction at scan_addr:
  - OP_OPEN: depth+1.
  - OP_CLOSE: depth-1.
  - Anything else: no change.
  - Close with depth==1 → match; pc_target=scan_addr+1; → DONE.
  - Otherwise scan_addr+1.
- BWD: mirror of FWD.
  - OP_CLOSE: depth+1.
  - OP_OPEN: depth-1.
  - Open with depth==1 → match; pc_target=scan_addr+1; → DONE.
  - Otherwise scan_addr-1.
- DONE: pc_load=1 for exactly this cycle, busy=1; → IDLE.
- busy=1 in FWD, BWD, DONE and FAULT; 0 in IDLE.
- Latency: match d instructions from pc → start at cycle 0, pc_load at cycle d+1, busy high cycles 1..d+1.
- Depth overflow: increment from all-ones → FAULT; error=1; no pc_load.
- Address wrap without a match → FAULT:
  - FWD: examined address all-ones and not a match.
  - BWD: examined address 0 and not a match.
- FAULT: busy=1, error=1; held until reset (core stays stalled).
- Starts asserted while not IDLE are ignored.
- Reset mid-scan: immediate IDLE; no pc_load is ever issued for the aborted scan.
- All arithmetic unsigned, modulo 2^PC_W; wrap is detected, never silently taken.

Optional Feature:
- Macro: LOOP_SCAN_CACHE_EN.
- Defined:
  - One-entry jump cache {valid, dir, src_pc, target}, written on every DONE.
  - A start whose dir and pc match a valid entry goes straight to DONE: pc_load next cycle (latency 1), target from the cache.
  - Cache invalidated on reset.
- Undefined: no cache; every start performs a full scan.

Test Plan:
- Program "[]" at pc=10, start_fwd → scan_addr=11 in cycle 1; pc_load in cycle 2 with pc_target=12; busy high cycles 1–2.
- Nested "[+[-]>]" at pc=0, start_fwd → depth trace 1,1,2,2,1,1,0; pc_load cycle 7, pc_target=7.
- Same program, start_bwd at pc=6 → match at 0; pc_load cycle 7, pc_target=1.
- Forward scan with no ']' starting at pc=16'hFFFD → FAULT after 16'hFFFF examined; error=1, busy stays 1, no pc_load; reset clears both.
- DEPTH_W=2, four consecutive '[' after start → FAULT on the 4th open (depth 3→overflow); error=1.
- Assert reset at cycle 3 of a 10-instruction scan → busy=0 immediately; no pc_load afterwards. With LOOP_SCAN_CACHE_EN defined, repeat the first scenario twice: second pc_load arrives 1 cycle after start.
